// File: rtl/uart_dma_pkg.sv
// Shared constants and state encoding for the UART host DMA engine.
// Command codes, response bytes and status-byte layout live here.
package uart_dma_pkg;

    localparam logic [7:0] CMD_UB_WR    = 8'h01;
    localparam logic [7:0] CMD_WT_WR    = 8'h02;
    localparam logic [7:0] CMD_INSTR_WR = 8'h03;
    localparam logic [7:0] CMD_UB_RD    = 8'h04;
    localparam logic [7:0] CMD_EXEC     = 8'h05;
    localparam logic [7:0] CMD_STATUS   = 8'h06;

    localparam logic [7:0] RSP_ACK = 8'hA5;
    localparam logic [7:0] RSP_NAK = 8'h5A;

    localparam int STB_SYS_BUSY = 0;
    localparam int STB_SYS_DONE = 1;
    localparam int STB_VPU_BUSY = 2;
    localparam int STB_VPU_DONE = 3;
    localparam int STB_UB_BUSY  = 4;
    localparam int STB_UB_DONE  = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_CHECK,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_SEND,
        ST_RD_CHK,
        ST_RESP,
        ST_EXEC
    } state_e;

    function automatic logic is_frame_cmd(input logic [7:0] c);
        return (c == CMD_UB_WR) || (c == CMD_WT_WR) ||
               (c == CMD_INSTR_WR) || (c == CMD_UB_RD);
    endfunction

endpackage

// File: rtl/dma_word_assembler.sv
// Packs a byte stream into NBYTES-wide words, first byte in the MSB lane.
// A word (or an MSB-justified partial word on in_last) is strobed one cycle later.
module dma_word_assembler #(
    parameter int NBYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    output logic              word_valid,
    output logic [8*NBYTES-1:0] word_data
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES + 1);

    logic [W-1:0]  sh_q, sh_d, nxt;
    logic [CW-1:0] cnt_q, cnt_d, pad;
    logic [W-1:0]  wd_q, wd_d;
    logic          wv_q, wv_d;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        wd_d  = wd_q;
        wv_d  = 1'b0;
        nxt   = (sh_q << 8) | W'(in_byte);
        pad   = CW'(NBYTES - 1) - cnt_q;
        if (clr) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (in_valid) begin
            if (cnt_q == CW'(NBYTES - 1) || in_last) begin
                // Low lanes of a short word shift in as zeros.
                wd_d  = nxt << {pad, 3'b000};
                wv_d  = 1'b1;
                sh_d  = '0;
                cnt_d = '0;
            end else begin
                sh_d  = nxt;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
            wd_q  <= '0;
            wv_q  <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
            wd_q  <= wd_d;
            wv_q  <= wv_d;
        end
    end

    assign word_valid = wv_q;
    assign word_data  = wd_q;

endmodule

// File: rtl/uart_dma_engine.sv
// Framed-command DMA engine between a UART byte stream and TPU memories.
// Handles checksummed writes, exact-length UB readback, EXEC and STATUS.
module uart_dma_engine
    import uart_dma_pkg::*;
#(
    parameter int UB_BYTES       = 32,
    parameter int WT_BYTES       = 8,
    parameter int INSTR_BYTES    = 4,
    parameter int UB_ADDR_W      = 8,
    parameter int WT_ADDR_W      = 10,
    parameter int INSTR_ADDR_W   = 5,
    parameter int RD_LATENCY     = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      ub_wr_en,
    output logic [UB_ADDR_W-1:0]      ub_wr_addr,
    output logic [8*UB_BYTES-1:0]     ub_wr_data,
    output logic                      ub_rd_en,
    output logic [UB_ADDR_W-1:0]      ub_rd_addr,
    input  logic [8*UB_BYTES-1:0]     ub_rd_data,
    output logic                      wt_wr_en,
    output logic [WT_ADDR_W-1:0]      wt_wr_addr,
    output logic [8*WT_BYTES-1:0]     wt_wr_data,
    output logic                      instr_wr_en,
    output logic [INSTR_ADDR_W-1:0]   instr_wr_addr,
    output logic [8*INSTR_BYTES-1:0]  instr_wr_data,
    output logic                      start_execution,
    input  logic                      sys_busy,
    input  logic                      sys_done,
    input  logic                      vpu_busy,
    input  logic                      vpu_done,
    input  logic                      ub_busy,
    input  logic                      ub_done,
    output logic [3:0]                debug_state,
    output logic [7:0]                err_count
);

    localparam int UBW = 8 * UB_BYTES;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WW  = $clog2(RD_LATENCY + 1);
    localparam int BW  = $clog2(UB_BYTES + 1);

    state_e        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [1:0]    hdr_cnt_q, hdr_cnt_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   rem_q, rem_d;
    logic [7:0]    chk_q, chk_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic [UBW-1:0] rd_buf_q, rd_buf_d;
    logic [7:0]    rd_xor_q, rd_xor_d;
    logic [BW-1:0] bidx_q, bidx_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          start_q, start_d;
    logic [7:0]    err_q, err_d;

    logic          pay_valid, pay_last, asm_clr, any_wr, tx_acc, tmo_hit;
    logic          resp_load, resp_nak;
    logic [7:0]    resp_byte, status;
    logic [15:0]   hdr_len;

    assign asm_clr  = (state_q == ST_IDLE);
    assign pay_last = (rem_q == 16'd1);
    assign any_wr   = ub_wr_en | wt_wr_en | instr_wr_en;
    assign tx_acc   = tx_valid_q & tx_ready;
    assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign hdr_len  = {len_q[15:8], rx_data};

    always_comb begin
        status = '0;
        status[STB_SYS_BUSY] = sys_busy;
        status[STB_SYS_DONE] = sys_done;
        status[STB_VPU_BUSY] = vpu_busy;
        status[STB_VPU_DONE] = vpu_done;
        status[STB_UB_BUSY]  = ub_busy;
        status[STB_UB_DONE]  = ub_done;
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        hdr_cnt_d  = hdr_cnt_q;
        addr_d     = any_wr ? addr_q + 16'd1 : addr_q;
        len_d      = len_q;
        rem_d      = rem_q;
        chk_d      = chk_q;
        tmo_d      = tmo_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        rd_buf_d   = rd_buf_q;
        rd_xor_d   = rd_xor_q;
        bidx_d     = bidx_q;
        wcnt_d     = wcnt_q;
        start_d    = 1'b0;
        pay_valid  = 1'b0;
        resp_load  = 1'b0;
        resp_nak   = 1'b0;
        resp_byte  = RSP_ACK;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (is_frame_cmd(rx_data)) begin
                        cmd_d     = rx_data;
                        chk_d     = rx_data;
                        hdr_cnt_d = '0;
                        tmo_d     = '0;
                        state_d   = ST_HDR;
                    end else if (rx_data == CMD_EXEC) begin
                        state_d = ST_EXEC;
                    end else if (rx_data == CMD_STATUS) begin
                        resp_load = 1'b1;
                        resp_byte = status;
                    end
                end
            end
            ST_HDR: begin
                if (rx_valid) begin
                    chk_d     = chk_q ^ rx_data;
                    tmo_d     = '0;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    case (hdr_cnt_q)
                        2'd0: addr_d[15:8] = rx_data;
                        2'd1: addr_d[7:0]  = rx_data;
                        2'd2: len_d[15:8]  = rx_data;
                        default: begin
                            len_d[7:0] = rx_data;
                            rem_d      = hdr_len;
                            if (cmd_q != CMD_UB_RD && hdr_len != 16'd0)
                                state_d = ST_PAYLOAD;
                            else
                                state_d = ST_CHECK;
                        end
                    endcase
                end else if (tmo_hit) begin
                    resp_load = 1'b1;
                    resp_nak  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    chk_d     = chk_q ^ rx_data;
                    tmo_d     = '0;
                    pay_valid = 1'b1;
                    rem_d     = rem_q - 16'd1;
                    if (pay_last)
                        state_d = ST_CHECK;
                end else if (tmo_hit) begin
                    resp_load = 1'b1;
                    resp_nak  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == chk_q && cmd_q == CMD_UB_RD) begin
                        rem_d    = len_q;
                        rd_xor_d = '0;
                        state_d  = (len_q == 16'd0) ? ST_RD_CHK
                                                    : ST_RD_ISSUE;
                    end else begin
                        resp_load = 1'b1;
                        resp_nak  = (rx_data != chk_q);
                    end
                end else if (tmo_hit) begin
                    resp_load = 1'b1;
                    resp_nak  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RD_ISSUE: begin
                wcnt_d  = WW'(RD_LATENCY - 1);
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (wcnt_q == '0) begin
                    tx_data_d  = ub_rd_data[7:0];
                    tx_valid_d = 1'b1;
                    rd_buf_d   = ub_rd_data >> 8;
                    bidx_d     = '0;
                    state_d    = ST_RD_SEND;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            ST_RD_SEND: begin
                if (tx_acc) begin
                    rd_xor_d = rd_xor_q ^ tx_data_q;
                    rem_d    = rem_q - 16'd1;
                    bidx_d   = bidx_q + 1'b1;
                    if (pay_last) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_RD_CHK;
                    end else if (bidx_q == BW'(UB_BYTES - 1)) begin
                        tx_valid_d = 1'b0;
                        addr_d     = addr_q + 16'd1;
                        state_d    = ST_RD_ISSUE;
                    end else begin
                        tx_data_d = rd_buf_q[7:0];
                        rd_buf_d  = rd_buf_q >> 8;
                    end
                end
            end
            ST_RD_CHK: begin
                resp_load = 1'b1;
                resp_byte = rd_xor_q;
            end
            ST_RESP: begin
                if (tx_acc) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_EXEC: begin
                resp_load = 1'b1;
                resp_nak  = sys_busy;
                start_d   = !sys_busy;
            end
            default: state_d = ST_IDLE;
        endcase
        if (resp_load) begin
            tx_data_d  = resp_nak ? RSP_NAK : resp_byte;
            tx_valid_d = 1'b1;
            state_d    = ST_RESP;
        end
        err_d = (resp_load && resp_nak && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            hdr_cnt_q  <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            rem_q      <= '0;
            chk_q      <= '0;
            tmo_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            rd_buf_q   <= '0;
            rd_xor_q   <= '0;
            bidx_q     <= '0;
            wcnt_q     <= '0;
            start_q    <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            hdr_cnt_q  <= hdr_cnt_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            chk_q      <= chk_d;
            tmo_q      <= tmo_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            rd_buf_q   <= rd_buf_d;
            rd_xor_q   <= rd_xor_d;
            bidx_q     <= bidx_d;
            wcnt_q     <= wcnt_d;
            start_q    <= start_d;
            err_q      <= err_d;
        end
    end

    dma_word_assembler #(.NBYTES(UB_BYTES)) u_ub_asm (
        .clk(clk), .rst(rst), .clr(asm_clr),
        .in_valid(pay_valid && cmd_q == CMD_UB_WR),
        .in_byte(rx_data), .in_last(pay_last),
        .word_valid(ub_wr_en), .word_data(ub_wr_data)
    );

    dma_word_assembler #(.NBYTES(WT_BYTES)) u_wt_asm (
        .clk(clk), .rst(rst), .clr(asm_clr),
        .in_valid(pay_valid && cmd_q == CMD_WT_WR),
        .in_byte(rx_data), .in_last(pay_last),
        .word_valid(wt_wr_en), .word_data(wt_wr_data)
    );

    dma_word_assembler #(.NBYTES(INSTR_BYTES)) u_in_asm (
        .clk(clk), .rst(rst), .clr(asm_clr),
        .in_valid(pay_valid && cmd_q == CMD_INSTR_WR),
        .in_byte(rx_data), .in_last(pay_last),
        .word_valid(instr_wr_en), .word_data(instr_wr_data)
    );

    assign ub_wr_addr      = addr_q[UB_ADDR_W-1:0];
    assign wt_wr_addr      = addr_q[WT_ADDR_W-1:0];
    assign instr_wr_addr   = addr_q[INSTR_ADDR_W-1:0];
    assign ub_rd_en        = (state_q == ST_RD_ISSUE);
    assign ub_rd_addr      = addr_q[UB_ADDR_W-1:0];
    assign tx_data         = tx_data_q;
    assign tx_valid        = tx_valid_q;
    assign start_execution = start_q;
    assign debug_state     = state_q;
    assign err_count       = err_q;

endmodule

// File: tb/tb_uart_dma_engine.sv
// Directed bench for uart_dma_engine: vector table for single-byte frames,
// hand sequences for writes, readback, checksum errors and timeout.
module tb_uart_dma_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         ub_wr_en;
    logic [7:0]   ub_wr_addr;
    logic [255:0] ub_wr_data;
    logic         ub_rd_en;
    logic [7:0]   ub_rd_addr;
    logic [255:0] ub_rd_data;
    logic         wt_wr_en;
    logic [9:0]   wt_wr_addr;
    logic [63:0]  wt_wr_data;
    logic         instr_wr_en;
    logic [4:0]   instr_wr_addr;
    logic [31:0]  instr_wr_data;
    logic         start_execution;
    logic         sys_busy, sys_done, vpu_busy, vpu_done, ub_busy, ub_done;
    logic [3:0]   debug_state;
    logic [7:0]   err_count;

    uart_dma_engine #(
        .UB_BYTES(32), .WT_BYTES(8), .INSTR_BYTES(4),
        .UB_ADDR_W(8), .WT_ADDR_W(10), .INSTR_ADDR_W(5),
        .RD_LATENCY(2), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr), .ub_wr_data(ub_wr_data),
        .ub_rd_en(ub_rd_en), .ub_rd_addr(ub_rd_addr), .ub_rd_data(ub_rd_data),
        .wt_wr_en(wt_wr_en), .wt_wr_addr(wt_wr_addr), .wt_wr_data(wt_wr_data),
        .instr_wr_en(instr_wr_en), .instr_wr_addr(instr_wr_addr),
        .instr_wr_data(instr_wr_data),
        .start_execution(start_execution),
        .sys_busy(sys_busy), .sys_done(sys_done),
        .vpu_busy(vpu_busy), .vpu_done(vpu_done),
        .ub_busy(ub_busy), .ub_done(ub_done),
        .debug_state(debug_state), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int exp_err = 0;
    bit stall_en = 1'b0;

    logic [7:0]   txq[$];
    logic [15:0]  ub_a[$], wt_a[$], in_a[$], rd_a[$];
    logic [255:0] ub_d[$], wt_d[$], in_d[$];
    int start_cnt = 0;
    int multi_wr = 0;
    int stall_viol = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] pay [64];

    function automatic logic [7:0] gen(input logic [7:0] a, input int i);
        return a * 8'd7 + 8'(i * 3) + 8'd1;
    endfunction

    function automatic logic [255:0] gen_word(input logic [7:0] a);
        logic [255:0] w;
        for (int i = 0; i < 32; i++) w[8*i +: 8] = gen(a, i);
        return w;
    endfunction

    logic [1:0] pv;
    logic [7:0] pa [2];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv    <= '0;
            pa[0] <= '0;
            pa[1] <= '0;
        end else begin
            pv    <= {pv[0], ub_rd_en};
            pa[0] <= ub_rd_addr;
            pa[1] <= pa[0];
        end
    end
    assign ub_rd_data = pv[1] ? gen_word(pa[1]) : '0;

    always @(negedge clk) begin
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        if (ub_wr_en) begin
            ub_a.push_back(16'(ub_wr_addr));
            ub_d.push_back(ub_wr_data);
        end
        if (wt_wr_en) begin
            wt_a.push_back(16'(wt_wr_addr));
            wt_d.push_back(256'(wt_wr_data));
        end
        if (instr_wr_en) begin
            in_a.push_back(16'(instr_wr_addr));
            in_d.push_back(256'(instr_wr_data));
        end
        if (ub_rd_en) rd_a.push_back(16'(ub_rd_addr));
        if (start_execution) start_cnt <= start_cnt + 1;
        if (32'(ub_wr_en) + 32'(wt_wr_en) + 32'(instr_wr_en) > 1)
            multi_wr <= multi_wr + 1;
        if (prev_stall && (!tx_valid || tx_data != prev_data))
            stall_viol <= stall_viol + 1;
        prev_stall <= tx_valid && !tx_ready;
        prev_data  <= tx_data;
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [15:0] addr,
                              input logic [15:0] len, input bit bad);
        logic [7:0] c;
        c = cmd ^ addr[15:8] ^ addr[7:0] ^ len[15:8] ^ len[7:0];
        send_byte(cmd);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        if (cmd != 8'h04) begin
            for (int i = 0; i < int'(len); i++) begin
                send_byte(pay[i]);
                c = c ^ pay[i];
            end
        end
        send_byte(bad ? ~c : c);
    endtask

    task automatic wait_tx(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (txq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (txq.size() < n) begin
            failures++;
            $display("FAIL %s: tx count %0d expected %0d within %0d cycles",
                     name, txq.size(), n, budget);
        end
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [5:0] st;
        bit         resp;
        logic [7:0] exp_tx;
        int         exp_start;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int base, rbase, ubb, wtb, inb, sb;
        logic [255:0] e;
        logic [7:0] x;

        vecs[0] = '{8'h06, 6'b000000, 1'b1, 8'h00, 0};
        vecs[1] = '{8'h06, 6'b101010, 1'b1, 8'h2A, 0};
        vecs[2] = '{8'h06, 6'b010101, 1'b1, 8'h15, 0};
        vecs[3] = '{8'h06, 6'b111111, 1'b1, 8'h3F, 0};
        vecs[4] = '{8'h05, 6'b000001, 1'b1, 8'h5A, 0};
        vecs[5] = '{8'h05, 6'b000000, 1'b1, 8'hA5, 1};
        vecs[6] = '{8'h05, 6'b111110, 1'b1, 8'hA5, 1};
        vecs[7] = '{8'h00, 6'b000000, 1'b0, 8'h00, 0};
        vecs[8] = '{8'hFF, 6'b000000, 1'b0, 8'h00, 0};

        rst = 1'b1;
        rx_data = '0;
        rx_valid = 1'b0;
        {ub_done, ub_busy, vpu_done, vpu_busy, sys_done, sys_busy} = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", 256'(tx_valid), 0);
        check("rst_tx_data", 256'(tx_data), 0);
        check("rst_wr_en", 256'({ub_wr_en, wt_wr_en, instr_wr_en}), 0);
        check("rst_ub_wr_data", ub_wr_data, 0);
        check("rst_rd_en", 256'(ub_rd_en), 0);
        check("rst_start", 256'(start_execution), 0);
        check("rst_state", 256'(debug_state), 0);
        check("rst_err", 256'(err_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            base = txq.size();
            sb = start_cnt;
            {ub_done, ub_busy, vpu_done, vpu_busy, sys_done, sys_busy} = vecs[v].st;
            send_byte(vecs[v].cmd);
            if (vecs[v].resp) begin
                wait_tx($sformatf("vec%0d_resp", v), base + 1, 30);
                if (txq.size() > base)
                    check($sformatf("vec%0d_tx", v), 256'(txq[base]),
                          256'(vecs[v].exp_tx));
                if (vecs[v].exp_tx == 8'h5A) exp_err++;
            end else begin
                repeat (30) @(negedge clk);
                check($sformatf("vec%0d_silent", v), 256'(txq.size()),
                      256'(base));
            end
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_start", v), 256'(start_cnt - sb),
                  256'(vecs[v].exp_start));
            check($sformatf("vec%0d_err", v), 256'(err_count), 256'(exp_err));
        end
        {ub_done, ub_busy, vpu_done, vpu_busy, sys_done, sys_busy} = '0;

        base = txq.size();
        ubb = ub_a.size();
        for (int i = 0; i < 32; i++) pay[i] = 8'(i);
        send_frame(8'h01, 16'h0005, 16'h0020, 1'b0);
        wait_tx("ubw_resp", base + 1, 30);
        e = '0;
        for (int i = 0; i < 32; i++) e[255-8*i -: 8] = 8'(i);
        check("ubw_count", 256'(ub_a.size() - ubb), 1);
        if (ub_a.size() > ubb) begin
            check("ubw_addr", 256'(ub_a[ubb]), 256'h05);
            check("ubw_msb", 256'(ub_d[ubb][255:248]), 256'h00);
            check("ubw_lsb", 256'(ub_d[ubb][7:0]), 256'h1F);
            check("ubw_data", ub_d[ubb], e);
        end
        if (txq.size() > base) check("ubw_ack", 256'(txq[base]), 256'hA5);

        base = txq.size();
        wtb = wt_a.size();
        for (int i = 0; i < 12; i++) pay[i] = 8'hA0 + 8'(i);
        send_frame(8'h02, 16'h03FF, 16'h000C, 1'b0);
        wait_tx("wtw_resp", base + 1, 30);
        check("wtw_count", 256'(wt_a.size() - wtb), 2);
        if (wt_a.size() > wtb + 1) begin
            check("wtw_addr0", 256'(wt_a[wtb]), 256'h3FF);
            check("wtw_data0", wt_d[wtb], 256'h A0A1A2A3A4A5A6A7);
            check("wtw_addr1", 256'(wt_a[wtb+1]), 256'h000);
            check("wtw_data1", wt_d[wtb+1], 256'hA8A9AAAB00000000);
        end
        if (txq.size() > base) check("wtw_ack", 256'(txq[base]), 256'hA5);

        base = txq.size();
        inb = in_a.size();
        for (int i = 0; i < 12; i++) pay[i] = 8'h10 + 8'(i);
        send_frame(8'h03, 16'h001E, 16'h000C, 1'b1);
        wait_tx("inw_resp", base + 1, 30);
        exp_err++;
        check("inw_count", 256'(in_a.size() - inb), 3);
        if (in_a.size() > inb + 2) begin
            check("inw_addr0", 256'(in_a[inb]), 256'h1E);
            check("inw_data0", in_d[inb], 256'h10111213);
            check("inw_addr1", 256'(in_a[inb+1]), 256'h1F);
            check("inw_data1", in_d[inb+1], 256'h14151617);
            check("inw_addr2", 256'(in_a[inb+2]), 256'h00);
            check("inw_data2", in_d[inb+2], 256'h18191A1B);
        end
        if (txq.size() > base) check("inw_nak", 256'(txq[base]), 256'h5A);
        check("inw_err", 256'(err_count), 256'(exp_err));

        base = txq.size();
        rbase = rd_a.size();
        stall_en = 1'b1;
        send_frame(8'h04, 16'h0010, 16'h0028, 1'b0);
        wait_tx("ubr_resp", base + 41, 3000);
        stall_en = 1'b0;
        repeat (10) @(negedge clk);
        check("ubr_txcount", 256'(txq.size() - base), 41);
        check("ubr_rdcount", 256'(rd_a.size() - rbase), 2);
        if (rd_a.size() > rbase + 1) begin
            check("ubr_rdaddr0", 256'(rd_a[rbase]), 256'h10);
            check("ubr_rdaddr1", 256'(rd_a[rbase+1]), 256'h11);
        end
        x = '0;
        for (int k = 0; k < 40; k++) begin
            x = x ^ gen(8'h10 + 8'(k / 32), k % 32);
            if (txq.size() > base + k)
                check($sformatf("ubr_byte%0d", k), 256'(txq[base+k]),
                      256'(gen(8'h10 + 8'(k / 32), k % 32)));
        end
        if (txq.size() > base + 40) check("ubr_xor", 256'(txq[base+40]), 256'(x));
        check("ubr_stable", 256'(stall_viol), 0);

        base = txq.size();
        rbase = rd_a.size();
        send_frame(8'h04, 16'h0000, 16'h0008, 1'b1);
        wait_tx("badrd_resp", base + 1, 30);
        exp_err++;
        repeat (5) @(negedge clk);
        if (txq.size() > base) check("badrd_nak", 256'(txq[base]), 256'h5A);
        check("badrd_only", 256'(txq.size() - base), 1);
        check("badrd_nord", 256'(rd_a.size() - rbase), 0);

        base = txq.size();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (95) @(negedge clk);
        check("tmo_early", 256'(txq.size() - base), 0);
        wait_tx("tmo_resp", base + 1, 25);
        exp_err++;
        if (txq.size() > base) check("tmo_nak", 256'(txq[base]), 256'h5A);
        repeat (2) @(negedge clk);
        check("tmo_idle", 256'(debug_state), 0);
        check("tmo_err", 256'(err_count), 256'(exp_err));

        base = txq.size();
        ubb = ub_a.size();
        send_frame(8'h01, 16'h0007, 16'h0000, 1'b0);
        wait_tx("len0w_resp", base + 1, 30);
        if (txq.size() > base) check("len0w_ack", 256'(txq[base]), 256'hA5);
        check("len0w_nowr", 256'(ub_a.size() - ubb), 0);

        base = txq.size();
        rbase = rd_a.size();
        send_frame(8'h04, 16'h0003, 16'h0000, 1'b0);
        wait_tx("len0r_resp", base + 1, 30);
        repeat (10) @(negedge clk);
        if (txq.size() > base) check("len0r_byte", 256'(txq[base]), 256'h00);
        check("len0r_only", 256'(txq.size() - base), 1);
        check("len0r_nord", 256'(rd_a.size() - rbase), 0);
        check("no_coincide", 256'(multi_wr), 0);

        base = txq.size();
        send_byte(8'h02);
        send_byte(8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rstmid_silent", 256'(txq.size() - base), 0);
        check("rstmid_state", 256'(debug_state), 0);
        check("rstmid_err", 256'(err_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
